// File: rtl/iter_shifter.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROL) that advances up to STEP bit
// positions per clock behind a start/busy/done handshake.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   indata,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   outdata
);

    // state | meaning
    // IDLE  | waiting for start; done pulse is cleared here
    // SHIFT | stepping acc toward the result, rem positions still to go
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    // Wide enough to hold both a remaining count and the constant STEP/WIDTH.
    localparam int KW = ($clog2(WIDTH + 1) > SHAMT_W) ? $clog2(WIDTH + 1) : SHAMT_W;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_rem;
    logic [1:0]         r_mode;

    logic [KW-1:0]      w_rem_ext;
    logic [KW-1:0]      w_k;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_rem_ext = KW'(r_rem);
    assign w_k       = (w_rem_ext < KW'(STEP)) ? w_rem_ext : KW'(STEP);

    always_comb begin
        w_acc_next = r_acc;
        case (r_mode)
            MODE_SLL: w_acc_next = r_acc << w_k;
            MODE_SRL: w_acc_next = r_acc >> w_k;
            MODE_SRA: w_acc_next = $signed(r_acc) >>> w_k;
            default:  w_acc_next = (r_acc << w_k) | (r_acc >> (KW'(WIDTH) - w_k));
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_mode  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            outdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_acc   <= indata;
                        r_rem   <= shamt;
                        r_mode  <= mode;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_rem == '0) begin
                        outdata <= r_acc;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_rem <= r_rem - SHAMT_W'(w_k);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: three instances (STEP=1, STEP=4, and an
// 8-bit STEP=2 variant with out-of-range shift amounts), table + random + handshake.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  shamt = '0;
    logic [31:0] indata = '0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] out0, out1;
    logic [7:0]  out2;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode), .shamt(shamt),
        .indata(indata), .busy(busy0), .done(done0), .outdata(out0));

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .shamt(shamt),
        .indata(indata), .busy(busy1), .done(done1), .outdata(out1));

    iter_shifter #(.WIDTH(8), .SHAMT_W(4), .STEP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .shamt(shamt[3:0]),
        .indata(indata[7:0]), .busy(busy2), .done(done2), .outdata(out2));

    typedef struct {
        int          sel;
        logic [1:0]  m;
        int          sh;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    function automatic int width_of(input int sel);
        return (sel == 2) ? 8 : 32;
    endfunction

    function automatic int step_of(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 4 : 2;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    endfunction

    function automatic logic [31:0] cur_out(input int sel);
        return (sel == 0) ? out0 : (sel == 1) ? out1 : {24'h0, out2};
    endfunction

    // Reference result straight from the shift rules, computed in one go.
    function automatic logic [31:0] model(input int w, input logic [1:0] m,
                                          input int sh, input logic [31:0] d);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned x    = {32'h0, d} & mask;
        longint unsigned r;
        longint          s;
        int              rr;
        case (m)
            2'b00: r = (x << sh) & mask;
            2'b01: r = x >> sh;
            2'b10: begin
                if (((x >> (w - 1)) & 64'd1) != 64'd0) begin
                    s = longint'(x | ~mask);
                    r = longint'(s >>> sh) & mask;
                end else begin
                    r = x >> sh;
                end
            end
            default: begin
                rr = sh % w;
                r  = ((x << rr) | (x >> (w - rr))) & mask;
            end
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        start0 = (sel == 0) ? v : 1'b0;
        start1 = (sel == 1) ? v : 1'b0;
        start2 = (sel == 2) ? v : 1'b0;
    endtask

    // Called 1 time unit after an edge (cycle 0); returns 1 unit after the next edge (cycle 1).
    task automatic drive_start(input int sel, input logic [1:0] m, input int sh,
                               input logic [31:0] d);
        mode   = m;
        shamt  = 5'(sh);
        indata = d;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        mode   = ~m;
        shamt  = ~shamt;
        indata = ~d;
    endtask

    // From cycle 1 to the done cycle N+2. A start pulse with junk operands is
    // injected in cycle glitch (0 = none) to confirm it is ignored while busy.
    task automatic watch(input int sel, input int n, input logic [31:0] exp,
                         input string nm, input int glitch);
        logic ok = 1'b1;
        for (int c = 1; c <= n + 1; c++) begin
            if (!(cur_busy(sel) === 1'b1 && cur_done(sel) === 1'b0)) ok = 1'b0;
            if (c == glitch) begin
                indata = 32'hDEAD_BEEF;
                mode   = 2'b11;
                shamt  = 5'd1;
                set_start(sel, 1'b1);
            end else begin
                set_start(sel, 1'b0);
            end
            @(posedge clk); #1;
        end
        set_start(sel, 1'b0);
        check({nm, " busy window"}, {31'h0, ok}, 32'h1);
        check({nm, " done"}, {31'h0, cur_done(sel)}, 32'h1);
        check({nm, " busy low at done"}, {31'h0, cur_busy(sel)}, 32'h0);
        check({nm, " outdata"}, cur_out(sel), exp);
    endtask

    task automatic after_done(input int sel, input string nm);
        @(posedge clk); #1;
        check({nm, " done one cycle"}, {31'h0, cur_done(sel)}, 32'h0);
    endtask

    task automatic run_op(input int sel, input logic [1:0] m, input int sh,
                          input logic [31:0] d, input logic [31:0] exp, input string nm);
        int n = (sh + step_of(sel) - 1) / step_of(sel);
        drive_start(sel, m, sh, d);
        watch(sel, n, exp, nm, 0);
        after_done(sel, nm);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{0, 2'b00,  2, 32'h0000_0003, 32'h0000_000C});
        vecs.push_back('{0, 2'b10,  4, 32'h8000_0000, 32'hF800_0000});
        vecs.push_back('{0, 2'b01,  4, 32'h8000_0000, 32'h0800_0000});
        vecs.push_back('{1, 2'b11,  5, 32'h8000_0001, 32'h0000_0030});
        vecs.push_back('{0, 2'b00,  0, 32'h1234_5678, 32'h1234_5678});
        vecs.push_back('{0, 2'b00, 31, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{1, 2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{1, 2'b11,  0, 32'h1234_5678, 32'h1234_5678});
        vecs.push_back('{1, 2'b01,  7, 32'hF000_0000, 32'h01E0_0000});
        vecs.push_back('{2, 2'b00,  9, 32'h0000_00FF, 32'h0000_0000});
        vecs.push_back('{2, 2'b10, 12, 32'h0000_0080, 32'h0000_00FF});
        vecs.push_back('{2, 2'b01, 15, 32'h0000_00F0, 32'h0000_0000});
        vecs.push_back('{2, 2'b11,  9, 32'h0000_0081, 32'h0000_0003});
        vecs.push_back('{2, 2'b10,  3, 32'h0000_007F, 32'h0000_000F});
        vecs.push_back('{2, 2'b11,  8, 32'h0000_0081, 32'h0000_0081});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset busy%0d", s), {31'h0, cur_busy(s)}, 32'h0);
            check($sformatf("reset done%0d", s), {31'h0, cur_done(s)}, 32'h0);
            check($sformatf("reset out%0d", s), cur_out(s), 32'h0);
        end

        foreach (vecs[i])
            run_op(vecs[i].sel, vecs[i].m, vecs[i].sh, vecs[i].d, vecs[i].exp,
                   $sformatf("vec%0d", i));

        // Start while busy: ignored, first result survives, no extra done.
        drive_start(0, 2'b00, 4, 32'h0000_0001);
        watch(0, 4, 32'h0000_0010, "busy-start", 2);
        after_done(0, "busy-start");
        begin
            logic extra = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (done0 !== 1'b0 || busy0 !== 1'b0) extra = 1'b1;
                @(posedge clk); #1;
            end
            check("busy-start no second op", {31'h0, extra}, 32'h0);
            check("busy-start out held", out0, 32'h0000_0010);
        end

        // Start in the done cycle of the previous op.
        drive_start(1, 2'b00, 8, 32'h0000_0001);
        watch(1, 2, 32'h0000_0100, "chain A", 0);
        drive_start(1, 2'b01, 12, 32'hABCD_0000);
        check("chain B done dropped", {31'h0, done1}, 32'h0);
        watch(1, 3, 32'h000A_BCD0, "chain B", 0);
        after_done(1, "chain B");

        // Reset mid-operation (start in cycle 0, rst asserted in cycle 5).
        drive_start(0, 2'b00, 20, 32'h0000_0005);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", {31'h0, busy0}, 32'h0);
        check("abort done", {31'h0, done0}, 32'h0);
        check("abort out", out0, 32'h0);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
                @(posedge clk); #1;
            end
            check("abort no done", {31'h0, seen}, 32'h0);
        end
        run_op(0, 2'b10, 3, 32'h8000_0010, 32'hF000_0002, "post-abort");

        // Randomised ops against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            int          sel = int'($urandom_range(0, 2));
            logic [1:0]  m   = 2'($urandom_range(0, 3));
            int          sh  = int'($urandom_range(0, (sel == 2) ? 15 : 31));
            logic [31:0] d   = $urandom;
            if (sel == 2) d = d & 32'h0000_00FF;
            run_op(sel, m, sh, d, model(width_of(sel), m, sh, d), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
